// File: rtl/fpacc_pkg.sv
// Shared FP32 field layout, sequencer state encoding and helpers for fpacc_seq.
package fpacc_pkg;

    localparam int FP32_W = 32;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } fpacc_state_e;

    function automatic logic fp32_is_naninf(input logic [FP32_W-1:0] x);
        return x[MAN_W +: EXP_W] == EXP_INF;
    endfunction

endpackage

// File: rtl/fpacc_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is visible on data_o while non-empty.
module fpacc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/fpacc_seq.sv
// Group accumulator sequencer driving a multi-cycle FP32 adder via start/done.
// Optional FPACC_NANINF_FLAG_EN adds a sticky per-group nan_inf output.
module fpacc_seq
    import fpacc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              add_start,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    input  logic [31:0]       add_sum,
    input  logic              add_done
`ifdef FPACC_NANINF_FLAG_EN
    ,
    output logic              nan_inf
`endif
);

    fpacc_state_e       state_q;
    logic [31:0]        acc_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, add_start_q;
    logic [31:0]        out_data_q, add_a_q, add_b_q;
    logic [CNT_W-1:0]   out_count_q;

    logic               push, pop, fifo_full, fifo_empty, head_last, add_fin;
    logic [FP32_W:0]    head;
    logic [31:0]        head_data;

    assign in_ready  = reset && !fifo_full;
    assign push      = in_valid && in_ready;
    assign head_last = head[FP32_W];
    assign head_data = head[FP32_W-1:0];
    assign add_fin   = (state_q == ST_ISSUE || state_q == ST_WAIT) && add_done;
    assign pop       = (state_q == ST_LOAD) || add_fin;
    assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    fpacc_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FP32_W + 1)) u_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .push_i (push),
        .data_i ({in_last, in_data}),
        .pop_i  (pop),
        .data_o (head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign add_start = add_start_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            add_start_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (cnt_q == '0) begin
                            state_q <= ST_LOAD;
                        end else begin
                            // Operands are registered here so they are already stable in ISSUE.
                            state_q     <= ST_ISSUE;
                            add_start_q <= 1'b1;
                            add_a_q     <= acc_q;
                            add_b_q     <= head_data;
                        end
                    end
                end
                ST_LOAD: begin
                    acc_q <= head_data;
                    cnt_q <= CNT_W'(1);
                    if (head_last) begin
                        state_q     <= ST_OUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= head_data;
                        out_count_q <= CNT_W'(1);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    add_start_q <= 1'b0;
                    if (add_done) begin
                        acc_q <= add_sum;
                        cnt_q <= cnt_d;
                        if (head_last) begin
                            state_q     <= ST_OUT;
                            out_valid_q <= 1'b1;
                            out_data_q  <= add_sum;
                            out_count_q <= cnt_d;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        out_count_q <= '0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef FPACC_NANINF_FLAG_EN
    logic naninf_q;

    // Flag cannot change while in OUT, so gating with out_valid gives the group's value.
    assign nan_inf = out_valid_q && naninf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            naninf_q <= 1'b0;
        end else if (state_q == ST_OUT && out_ready) begin
            naninf_q <= 1'b0;
        end else if (state_q == ST_LOAD && fp32_is_naninf(head_data)) begin
            naninf_q <= 1'b1;
        end else if (add_fin && fp32_is_naninf(add_sum)) begin
            naninf_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fpacc_seq.sv
// Directed bench for fpacc_seq with a behavioural multi-cycle adder and an output scoreboard.
module tb_fpacc_seq;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [31:0]      in_data = '0;
    logic             in_ready, out_valid, add_start, add_done;
    logic [31:0]      out_data, add_a, add_b, add_sum;
    logic [CNT_W-1:0] out_count;
`ifdef FPACC_NANINF_FLAG_EN
    logic             nan_inf;
`endif

    always #5 clk = ~clk;

    fpacc_seq #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_done(add_done)
`ifdef FPACC_NANINF_FLAG_EN
        , .nan_inf(nan_inf)
`endif
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Adder model: zero/Inf/NaN operands finish in the start cycle; others take 6 cycles
    // and reread the operands at completion.
    function automatic logic fp_special(input logic [31:0] a, input logic [31:0] b);
        return a[30:0] == 0 || b[30:0] == 0 || a[30:23] == 8'hFF || b[30:23] == 8'hFF;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 0) return b;
        if (b[30:0] == 0) return a;
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        case ({a, b})
            64'h3F800000_40000000: return 32'h40400000;
            64'h40400000_40400000: return 32'h40C00000;
            64'h3F800000_3F800000: return 32'h40000000;
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    logic        mdl_done_q = 1'b0;
    logic [31:0] mdl_sum_q = '0;
    int          mdl_cnt = 0;

    assign add_done = add_start ? fp_special(add_a, add_b) : mdl_done_q;
    assign add_sum  = add_start ? fp_add(add_a, add_b) : mdl_sum_q;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdl_done_q <= 1'b0;
            mdl_sum_q  <= '0;
            mdl_cnt    <= 0;
        end else if (add_start && !fp_special(add_a, add_b)) begin
            mdl_done_q <= 1'b0;
            mdl_cnt    <= 6;
        end else if (mdl_cnt > 1) begin
            mdl_cnt <= mdl_cnt - 1;
        end else if (mdl_cnt == 1) begin
            mdl_cnt    <= 0;
            mdl_done_q <= 1'b1;
            mdl_sum_q  <= fp_add(add_a, add_b);
        end
    end

    typedef struct {
        logic [31:0]      data;
        logic [CNT_W-1:0] cnt;
        int               starts;
        logic             ni;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_starts = 0;
    logic mon_prev_start = 1'b0;

    task automatic expect_grp(input logic [31:0] d, input int c, input int s, input logic ni);
        exp_t e;
        e.data = d; e.cnt = CNT_W'(c); e.starts = s; e.ni = ni;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon_starts     = 0;
            mon_prev_start = 1'b0;
        end else begin
            if (add_start) begin
                chk("start_single_cycle", 32'(mon_prev_start), 0);
                mon_starts++;
            end
            mon_prev_start = add_start;
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", out_data, mon_e.data);
                    chk("out_count", 32'(out_count), 32'(mon_e.cnt));
                    chk("add_starts", mon_starts, mon_e.starts);
`ifdef FPACC_NANINF_FLAG_EN
                    chk("nan_inf", 32'(nan_inf), 32'(mon_e.ni));
`endif
                end
                mon_starts = 0;
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic l);
        int g = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("push_timeout", 32'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    endtask

    task automatic wait_drain(input string tag);
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        int g;
        int lat;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_add_start", 32'(add_start), 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // 1.0 + 2.0 + 3.0
        expect_grp(32'h40C00000, 3, 2, 1'b0);
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b0);
        push(32'h40400000, 1'b1);
        wait_drain("drain_sum3");

        // Single term passes through bit-exact
        expect_grp(32'hC1200000, 1, 0, 1'b0);
        push(32'hC1200000, 1'b1);
        wait_drain("drain_single");

        // Zero operand takes the fast path
        expect_grp(32'h40A00000, 2, 1, 1'b0);
        push(32'h00000000, 1'b0);
        push(32'h40A00000, 1'b1);
        g = 0;
        while (!add_start && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("fast_start_seen", 32'(add_start), 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("fast_latency_ok", 32'(lat >= 1 && lat <= 2), 1);
        wait_drain("drain_fast");

        // Output backpressure while the FIFO fills
        @(posedge clk) #1 out_ready = 1'b0;
        expect_grp(32'h40E00000, 1, 0, 1'b0);
        push(32'h40E00000, 1'b1);
        g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("bp_out_valid", 32'(out_valid), 1);
        expect_grp(32'h3F800000, 1, 0, 1'b0);
        expect_grp(32'h40000000, 1, 0, 1'b0);
        expect_grp(32'h40400000, 1, 0, 1'b0);
        expect_grp(32'h40800000, 1, 0, 1'b0);
        expect_grp(32'h40A00000, 1, 0, 1'b0);
        push(32'h3F800000, 1'b1);
        push(32'h40000000, 1'b1);
        push(32'h40400000, 1'b1);
        push(32'h40800000, 1'b1);
        chk("bp_in_ready_full", 32'(in_ready), 0);
        repeat (6) @(negedge clk);
        chk("bp_out_valid_held", 32'(out_valid), 1);
        chk("bp_out_data_stable", out_data, 32'h40E00000);
        chk("bp_in_ready_still_full", 32'(in_ready), 0);
        @(posedge clk) #1 out_ready = 1'b1;
        push(32'h40A00000, 1'b1);
        wait_drain("drain_bp");

        // Reset while the adder is busy
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b1);
        g = 0;
        while (!add_start && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("rw_start_seen", 32'(add_start), 1);
        repeat (2) @(negedge clk);
        chk("rw_start_low", 32'(add_start), 0);
        chk("rw_a_held", add_a, 32'h3F800000);
        chk("rw_b_held", add_b, 32'h40000000);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rw_add_start", 32'(add_start), 0);
        chk("rw_add_a", add_a, 0);
        chk("rw_add_b", add_b, 0);
        chk("rw_out_valid", 32'(out_valid), 0);
        chk("rw_out_data", out_data, 0);
        chk("rw_out_count", 32'(out_count), 0);
        chk("rw_in_ready", 32'(in_ready), 0);
        @(negedge clk) reset = 1'b1;
        expect_grp(32'h40000000, 2, 1, 1'b0);
        push(32'h3F800000, 1'b0);
        push(32'h3F800000, 1'b1);
        wait_drain("drain_after_reset");

`ifdef FPACC_NANINF_FLAG_EN
        expect_grp(32'h7F800000, 2, 1, 1'b1);
        push(32'h7F800000, 1'b0);
        push(32'h3F800000, 1'b1);
        wait_drain("drain_inf");
        expect_grp(32'h40400000, 2, 1, 1'b0);
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b1);
        wait_drain("drain_after_inf");
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
